// File: rtl/value_match_table.sv
// value_match_table: small fully-associative table of WIDTH-bit values.
// Entries are allocated at the lowest free index, released by index or all
// at once by flush, and searched by value with a one-cycle registered result
// that reports the lowest matching valid entry.
module value_match_table #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int IW    = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_alloc_valid,
    input  logic [WIDTH-1:0] i_alloc_value,
    output logic             o_alloc_ready,
    output logic [IW-1:0]    o_alloc_idx,
    input  logic             i_free_valid,
    input  logic [IW-1:0]    i_free_idx,
    input  logic             i_lookup_valid,
    input  logic [WIDTH-1:0] i_lookup_value,
    output logic             o_lookup_valid,
    output logic             o_lookup_hit,
    output logic [IW-1:0]    o_lookup_idx,
    output logic [IW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [IW:0] N_CNT = (IW+1)'(N);

    logic [N-1:0]     valid_q;
    logic [N-1:0]     valid_d;
    logic [WIDTH-1:0] value_q [N];
    logic [IW:0]      count_q;

    logic             full;
    logic [IW-1:0]    alloc_idx;
    logic             alloc_accept;
    logic             free_effective;
    logic             match_any;
    logic [IW-1:0]    match_idx;

    assign full          = (count_q == N_CNT);
    assign o_full        = full;
    assign o_empty       = (count_q == '0);
    assign o_alloc_ready = !full;
    assign o_alloc_idx   = alloc_idx;
    assign o_count       = count_q;

    // Lowest free entry; falls back to 0 when every entry is in use.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        alloc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IW'(i);
        end
    end

    // Accept conditions; a free only counts if it really releases an entry.
    always_comb begin
        alloc_accept   = i_alloc_valid && !full && !i_flush;
        free_effective = 1'b0;
        if (i_free_valid && !i_flush && ({1'b0, i_free_idx} < N_CNT)) begin
            free_effective = valid_q[i_free_idx];
        end
    end

    // Next valid vector. The allocated slot is free pre-edge, so it can never
    // be the slot being released in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (i_flush) begin
            valid_d = '0;
        end else begin
            if (free_effective) valid_d[i_free_idx] = 1'b0;
            if (alloc_accept)   valid_d[alloc_idx]  = 1'b1;
        end
    end

    // Lowest valid entry whose stored value equals the lookup key.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_q[i] && (value_q[i] == i_lookup_value)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    // Valid bits, occupancy count and registered lookup result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q        <= '0;
            count_q        <= '0;
            o_lookup_valid <= 1'b0;
            o_lookup_hit   <= 1'b0;
            o_lookup_idx   <= '0;
        end else begin
            // NOTE: state is written with non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            valid_q        <= valid_d;
            o_lookup_valid <= i_lookup_valid;
            o_lookup_hit   <= i_lookup_valid && match_any;
            o_lookup_idx   <= i_lookup_valid ? match_idx : '0;
            if (i_flush) begin
                count_q <= '0;
            end else if (alloc_accept && !free_effective) begin
                count_q <= count_q + (IW+1)'(1);
            end else if (free_effective && !alloc_accept) begin
                count_q <= count_q - (IW+1)'(1);
            end
        end
    end

    // Value storage, written only on an accepted allocation.
    always_ff @(posedge i_clk) begin
        // NOTE: the value array has no reset; an entry's contents are
        // meaningless until its valid bit is set, so resetting it only costs.
        if (alloc_accept) value_q[alloc_idx] <= i_alloc_value;
    end

endmodule

// File: tb/tb_value_match_table.sv
// Testbench for value_match_table: directed scenarios plus randomized
// traffic, checked against a behavioural table model and a lookup scoreboard.
module tb_value_match_table;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int IW    = $clog2(N);

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_alloc_valid = 1'b0;
    logic [WIDTH-1:0] i_alloc_value = '0;
    logic             o_alloc_ready;
    logic [IW-1:0]    o_alloc_idx;
    logic             i_free_valid = 1'b0;
    logic [IW-1:0]    i_free_idx = '0;
    logic             i_lookup_valid = 1'b0;
    logic [WIDTH-1:0] i_lookup_value = '0;
    logic             o_lookup_valid;
    logic             o_lookup_hit;
    logic [IW-1:0]    o_lookup_idx;
    logic [IW:0]      o_count;
    logic             o_full;
    logic             o_empty;

    value_match_table #(.WIDTH(WIDTH), .N(N)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_flush        (i_flush),
        .i_alloc_valid  (i_alloc_valid),
        .i_alloc_value  (i_alloc_value),
        .o_alloc_ready  (o_alloc_ready),
        .o_alloc_idx    (o_alloc_idx),
        .i_free_valid   (i_free_valid),
        .i_free_idx     (i_free_idx),
        .i_lookup_valid (i_lookup_valid),
        .i_lookup_value (i_lookup_value),
        .o_lookup_valid (o_lookup_valid),
        .o_lookup_hit   (o_lookup_hit),
        .o_lookup_idx   (o_lookup_idx),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
    } lkp_exp_t;

    lkp_exp_t exp_q[$];

    // Reference table: which slots hold a value, and what value.
    bit               m_valid [N];
    logic [WIDTH-1:0] m_value [N];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endtask

    // One clock of stimulus: check pre-edge status against the model, drive
    // the request, record the expected lookup result, then advance the model.
    task automatic cycle(input bit av, input logic [WIDTH-1:0] aval,
                         input bit fv, input int fidx,
                         input bit lv, input logic [WIDTH-1:0] lval,
                         input bit fl);
        int       cnt;
        int       slot;
        lkp_exp_t e;
        @(negedge i_clk);
        cnt  = m_count();
        slot = m_first_free();
        check("count",       o_count,       cnt);
        check("full",        o_full,        cnt == N);
        check("empty",       o_empty,       cnt == 0);
        check("alloc_ready", o_alloc_ready, cnt != N);
        check("alloc_idx",   o_alloc_idx,   (slot < 0) ? 0 : slot);

        i_alloc_valid  = av;
        i_alloc_value  = aval;
        i_free_valid   = fv;
        i_free_idx     = IW'(fidx);
        i_lookup_valid = lv;
        i_lookup_value = lval;
        i_flush        = fl;

        if (lv) begin
            e.hit = 1'b0;
            e.idx = '0;
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && m_value[i] == lval) begin
                    e.hit = 1'b1;
                    e.idx = IW'(i);
                    break;
                end
            end
            exp_q.push_back(e);
        end

        if (fl) begin
            m_clear();
        end else begin
            if (fv && fidx < N && m_valid[fidx]) m_valid[fidx] = 1'b0;
            if (av && slot >= 0) begin
                m_valid[slot] = 1'b1;
                m_value[slot] = aval;
            end
        end
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic alloc(input logic [WIDTH-1:0] v);
        cycle(1, v, 0, 0, 0, '0, 0);
    endtask

    task automatic lookup(input logic [WIDTH-1:0] v);
        cycle(0, '0, 0, 0, 1, v, 0);
    endtask

    task automatic after_edge();
        @(posedge i_clk);
        #2;
    endtask

    // Monitor: after every edge compare the lookup output with the scoreboard.
    always begin
        lkp_exp_t e;
        @(posedge i_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mon_lookup_valid", o_lookup_valid, 1);
            check("mon_lookup_hit",   o_lookup_hit,   e.hit);
            check("mon_lookup_idx",   o_lookup_idx,   e.idx);
        end else begin
            check("mon_idle_valid", o_lookup_valid, 0);
            check("mon_idle_hit",   o_lookup_hit,   0);
            check("mon_idle_idx",   o_lookup_idx,   0);
        end
    end

    initial begin
        m_clear();

        // Reset values, asynchronously while reset is held.
        #2;
        check("rst_count",       o_count,        0);
        check("rst_empty",       o_empty,        1);
        check("rst_full",        o_full,         0);
        check("rst_alloc_ready", o_alloc_ready,  1);
        check("rst_alloc_idx",   o_alloc_idx,    0);
        check("rst_lookup_valid", o_lookup_valid, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fill the table, then a dropped allocation and a missing lookup.
        alloc(32'hA); alloc(32'hB); alloc(32'hC); alloc(32'hD);
        after_edge();
        check("fill_full",  o_full,        1);
        check("fill_count", o_count,       4);
        check("fill_ready", o_alloc_ready, 0);
        cycle(1, 32'hE, 0, 0, 1, 32'hE, 0);
        after_edge();
        check("drop_e_hit", o_lookup_hit, 0);
        lookup(32'hE);
        after_edge();
        check("drop_e_hit2", o_lookup_hit, 0);
        check("drop_e_count", o_count, 4);
        cycle(0, '0, 0, 0, 0, '0, 1);

        // Hit at index 1, then a miss.
        alloc(32'hA); alloc(32'hB);
        lookup(32'hB);
        after_edge();
        check("hit_b_valid", o_lookup_valid, 1);
        check("hit_b_hit",   o_lookup_hit,   1);
        check("hit_b_idx",   o_lookup_idx,   1);
        lookup(32'h5);
        after_edge();
        check("miss_5_hit", o_lookup_hit, 0);
        check("miss_5_idx", o_lookup_idx, 0);

        // Full table: free and alloc together, alloc is dropped.
        alloc(32'hC); alloc(32'hD);
        cycle(1, 32'h7, 1, 2, 0, '0, 0);
        after_edge();
        check("free_alloc_count", o_count, 3);
        check("free_alloc_idx",   o_alloc_idx, 2);
        alloc(32'h7);
        after_edge();
        check("realloc_count", o_count, 4);
        lookup(32'h7);
        after_edge();
        check("realloc_idx", o_lookup_idx, 2);

        // Duplicate values return the lowest valid index.
        cycle(0, '0, 0, 0, 0, '0, 1);
        alloc(32'h9); alloc(32'h1); alloc(32'h9);
        lookup(32'h9);
        after_edge();
        check("dup_idx_first", o_lookup_idx, 0);
        cycle(0, '0, 1, 0, 1, 32'h9, 0);
        after_edge();
        check("dup_idx_same_cycle", o_lookup_idx, 0);
        lookup(32'h9);
        after_edge();
        check("dup_idx_after_free", o_lookup_idx, 2);

        // Flush overrides simultaneous alloc and free.
        cycle(0, '0, 0, 0, 0, '0, 1);
        alloc(32'h11); alloc(32'h22); alloc(32'h33);
        cycle(1, 32'h44, 1, 1, 0, '0, 1);
        after_edge();
        check("flush_count", o_count, 0);
        check("flush_empty", o_empty, 1);
        lookup(32'h22);
        after_edge();
        check("flush_miss", o_lookup_hit, 0);

        // Reset between edges with a lookup result pending.
        alloc(32'h55); alloc(32'h66);
        lookup(32'h66);
        @(posedge i_clk);
        #3;
        check("pre_rst_valid", o_lookup_valid, 1);
        i_rst_n        = 1'b0;
        i_alloc_valid  = 1'b0;
        i_free_valid   = 1'b0;
        i_lookup_valid = 1'b0;
        i_flush        = 1'b0;
        exp_q.delete();
        m_clear();
        #1;
        check("async_rst_valid",     o_lookup_valid, 0);
        check("async_rst_hit",       o_lookup_hit,   0);
        check("async_rst_count",     o_count,        0);
        check("async_rst_empty",     o_empty,        1);
        check("async_rst_alloc_idx", o_alloc_idx,    0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        alloc(32'h77);
        after_edge();
        check("post_rst_count", o_count, 1);
        lookup(32'h77);
        after_edge();
        check("post_rst_idx", o_lookup_idx, 0);

        // Randomized traffic over a small value space so duplicates and hits
        // are common.
        for (int n = 0; n < 400; n++) begin
            bit               av;
            bit               fv;
            bit               lv;
            bit               fl;
            logic [WIDTH-1:0] aval;
            logic [WIDTH-1:0] lval;
            av   = ($urandom_range(0, 99) < 50);
            fv   = ($urandom_range(0, 99) < 40);
            lv   = ($urandom_range(0, 99) < 60);
            fl   = ($urandom_range(0, 99) < 4);
            aval = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 7));
            lval = WIDTH'($urandom_range(0, 7));
            cycle(av, aval, fv, int'($urandom_range(0, N - 1)), lv, lval, fl);
        end

        idle();
        idle();
        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge i_clk);
                budget--;
            end
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/value_match_table.md
VALUE_MATCH_TABLE -- requirements
Module: value_match_table

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each stored value and each lookup key.
REQ-002 Parameter N, default 4: number of table entries; N >= 2.
REQ-003 Localparam IW = $clog2(N): width of entry index and count ports; count port is IW+1 bits.
REQ-004 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 i_flush  input  1  invalidates all entries.
REQ-007 i_alloc_valid  input  1  request to insert i_alloc_value.
REQ-008 i_alloc_value  input  WIDTH  value to insert.
REQ-009 o_alloc_ready  output  1  at least one free entry (combinational, = !o_full).
REQ-010 o_alloc_idx  output  IW  index the next accepted allocation uses (lowest free index; 0 when full).
REQ-011 i_free_valid  input  1  request to release entry i_free_idx.
REQ-012 i_free_idx  input  IW  entry to release.
REQ-013 i_lookup_valid  input  1  lookup request.
REQ-014 i_lookup_value  input  WIDTH  key to compare against all valid entries.
REQ-015 o_lookup_valid  output  1  registered lookup result valid.
REQ-016 o_lookup_hit  output  1  registered: key matched at least one valid entry.
REQ-017 o_lookup_idx  output  IW  registered: lowest matching index; 0 on miss.
REQ-018 o_count  output  IW+1  number of valid entries.
REQ-019 o_full / o_empty  output  1 each  count == N / count == 0.

Function
REQ-020 Storage: N value registers plus N valid bits; invalid entries never match.
REQ-021 Allocation accepted when i_alloc_valid && o_alloc_ready && !i_flush; writes value into entry o_alloc_idx and sets its valid bit at the next edge.
REQ-022 Allocation when full is dropped silently; no state change.
REQ-023 Free accepted when i_free_valid && !i_flush; clears valid bit of i_free_idx at the next edge; freeing an already-invalid entry or an index >= N is a no-op.
REQ-024 Simultaneous accepted alloc and free: both take effect in the same cycle; the freed slot is not eligible for that cycle's allocation (o_alloc_idx reflects pre-edge state); o_count unchanged.
REQ-025 Free targeting the index being allocated in the same cycle cannot occur (that index is invalid pre-edge), so the free is a no-op and the allocation stands.
REQ-026 i_flush clears all valid bits at the next edge; overrides alloc and free in the same cycle; value registers need not be cleared.
REQ-027 Lookup latency is 1 cycle: o_lookup_valid = registered i_lookup_valid; hit/idx are computed against pre-edge table contents (same-cycle alloc/free/flush not visible).
REQ-028 Duplicate values are permitted; a lookup returns the lowest matching index.
REQ-029 When i_lookup_valid is 0, o_lookup_valid goes 0 next cycle; o_lookup_hit and o_lookup_idx go to 0.
REQ-030 o_count is a register updated as count + alloc_accepted - free_effective, or 0 on flush; it never exceeds N or wraps below 0.

Reset
REQ-031 While i_rst_n is low, all valid bits, o_count, o_lookup_valid, o_lookup_hit, o_lookup_idx are 0 asynchronously; o_empty=1, o_full=0, o_alloc_ready=1, o_alloc_idx=0.
REQ-032 Reset asserted mid-operation discards all entries and any pending lookup result; first post-reset allocation uses index 0.

Verification
REQ-033 N=4: allocate 0xA, 0xB, 0xC, 0xD on consecutive cycles -> indices 0,1,2,3; o_full=1, o_count=4, o_alloc_ready=0; fifth alloc 0xE dropped, lookup 0xE -> hit=0.
REQ-034 Table {0:0xA, 1:0xB}; lookup 0xB -> next cycle o_lookup_valid=1, hit=1, idx=1; lookup 0x5 -> hit=0, idx=0.
REQ-035 Full table; same cycle free idx 2 and alloc 0x7 -> alloc dropped (full pre-edge), entry 2 invalid, count=3; next cycle alloc 0x7 -> idx 2, count=4.
REQ-036 Entries 0 and 2 both hold 0x9; lookup 0x9 -> idx=0; free 0 and lookup 0x9 same cycle -> idx=0; following lookup -> idx=2.
REQ-037 Three entries valid; assert i_flush together with alloc and free -> next cycle count=0, o_empty=1, lookup of any prior value misses.
REQ-038 Drop i_rst_n asynchronously between clock edges with two entries valid and a lookup result pending -> outputs clear immediately; after release, first alloc gets idx 0.
